// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub: operands and opcode in, status and result out.
// The master side issues start with operands; the slave side reports busy/done and the held result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, WIDTH/DIGIT RUN cycles, then a one-cycle DONE.
// No backpressure; start is only honoured in IDLE or DONE and ignored while busy.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]       a_sr;
  logic [WIDTH-1:0]       b_sr;
  logic [WIDTH-1:0]       r_sr;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       s_q;
  logic                   cout_q;
  logic                   ovf_q;

  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] r_wide;
  logic                   msb_cin;
  logic                   load;
  logic                   last;

  assign load = bus.start && ((state == IDLE) || (state == DONE));
  assign last = (state == RUN) && (cnt == LAST);

  // One digit of ripple add; the result register fills from the MSB side.
  assign dsum    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign r_wide  = {dsum[DIGIT-1:0], r_sr};
  // On the final digit the top bit is the operand MSB, so this recovers the carry into it.
  assign msb_cin = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      // Subtract as a + ~b + 1: invert b here and seed the carry with sub.
      a_sr  <= bus.a;
      b_sr  <= bus.b ^ {WIDTH{bus.sub}};
      r_sr  <= '0;
      carry <= bus.sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      r_sr  <= r_wide[WIDTH+DIGIT-1:DIGIT];
      carry <= dsum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last) begin
        s_q    <= r_wide[WIDTH+DIGIT-1:DIGIT];
        cout_q <= dsum[DIGIT];
        ovf_q  <= msb_cin ^ dsum[DIGIT];
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized checks of serial_addsub at WIDTH=8 for DIGIT in {1,2,4,8},
// against an arithmetic reference model of sum/difference, carry/no-borrow and signed overflow.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] start_v = 4'b0;
  logic       sub_d = 1'b0;
  logic [7:0] a_d = 8'h00;
  logic [7:0] b_d = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_s [4];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if1 ();
  serial_addsub_if #(.WIDTH(8)) if2 ();
  serial_addsub_if #(.WIDTH(8)) if4 ();
  serial_addsub_if #(.WIDTH(8)) if8 ();

  assign if1.start = start_v[0];
  assign if2.start = start_v[1];
  assign if4.start = start_v[2];
  assign if8.start = start_v[3];
  assign if1.sub = sub_d; assign if1.a = a_d; assign if1.b = b_d;
  assign if2.sub = sub_d; assign if2.a = a_d; assign if2.b = b_d;
  assign if4.sub = sub_d; assign if4.a = a_d; assign if4.b = b_d;
  assign if8.sub = sub_d; assign if8.a = a_d; assign if8.b = b_d;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  function automatic logic get_busy(int sel);
    case (sel)
      0: return if1.busy;
      1: return if2.busy;
      2: return if4.busy;
      default: return if8.busy;
    endcase
  endfunction

  function automatic logic get_done(int sel);
    case (sel)
      0: return if1.done;
      1: return if2.done;
      2: return if4.done;
      default: return if8.done;
    endcase
  endfunction

  function automatic logic [7:0] get_s(int sel);
    case (sel)
      0: return if1.s;
      1: return if2.s;
      2: return if4.s;
      default: return if8.s;
    endcase
  endfunction

  function automatic logic get_cout(int sel);
    case (sel)
      0: return if1.cout;
      1: return if2.cout;
      2: return if4.cout;
      default: return if8.cout;
    endcase
  endfunction

  function automatic logic get_ovf(int sel);
    case (sel)
      0: return if1.ovf;
      1: return if2.ovf;
      2: return if4.ovf;
      default: return if8.ovf;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry, signed range for overflow.
  function automatic logic [9:0] ref_op(logic [7:0] a, logic [7:0] b, logic sub);
    int ua, ub, sa, sb, r, sr;
    logic [7:0] res;
    logic co, ov;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    r  = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    res = 8'(r);
    co  = sub ? (ua >= ub) : (r > 255);
    ov  = (sr > 127) || (sr < -128);
    return {ov, co, res};
  endfunction

  // Full operation on one instance: latency, busy length, held result, final outputs.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sub);
    int n;
    int cyc;
    logic [9:0] exp;
    n   = 8 >> sel;
    exp = ref_op(a, b, sub);
    a_d = a; b_d = b; sub_d = sub;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    a_d = $urandom; b_d = $urandom; sub_d = $urandom;
    chk("hold_s_in_run", get_s(sel), prev_s[sel]);
    cyc = 0;
    while (get_busy(sel) && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_cycles", cyc, n);
    chk("done_pulse", get_done(sel), 1'b1);
    chk("sum", get_s(sel), exp[7:0]);
    chk("cout", get_cout(sel), exp[8]);
    chk("ovf", get_ovf(sel), exp[9]);
    prev_s[sel] = exp[7:0];
    @(negedge clk);
    chk("done_one_cycle", get_done(sel), 1'b0);
  endtask

  initial begin
    int sel;
    logic saw_done;
    for (int i = 0; i < 4; i++) prev_s[i] = 8'h00;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", get_busy(i), 1'b0);
      chk("rst_done", get_done(i), 1'b0);
      chk("rst_s", get_s(i), 8'h00);
      chk("rst_cout_ovf", {get_cout(i), get_ovf(i)}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Wraparound with carry, signed overflow, subtract with borrow
    run_op(0, 8'hFF, 8'h01, 1'b0);
    run_op(0, 8'h7F, 8'h01, 1'b0);
    run_op(0, 8'h05, 8'h07, 1'b1);
    chk("d1_5m7", get_s(0), 8'hFE);
    run_op(2, 8'h80, 8'h01, 1'b1);
    chk("d4_80m1", {get_ovf(2), get_cout(2), get_s(2)}, {1'b1, 1'b1, 8'h7F});

    // Start mid-RUN is dropped; start held in DONE restarts with no IDLE cycle
    a_d = 8'h03; b_d = 8'h04; sub_d = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    a_d = 8'h11; b_d = 8'h22; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_still_busy", {get_busy(0), get_done(0)}, 2'b10);
    @(negedge clk);
    chk("midrun_done", get_done(0), 1'b1);
    chk("midrun_sum", get_s(0), 8'h07);
    a_d = 8'h10; b_d = 8'h01; sub_d = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_busy", {get_busy(0), get_done(0)}, 2'b10);
    repeat (4) @(negedge clk);
    chk("b2b_hold_s", get_s(0), 8'h07);
    repeat (4) @(negedge clk);
    chk("b2b_done", get_done(0), 1'b1);
    chk("b2b_sum", get_s(0), 8'h11);
    @(negedge clk);

    // Reset during RUN aborts with no done pulse and clears outputs
    a_d = 8'h55; b_d = 8'h11; sub_d = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy_done", {get_busy(0), get_done(0)}, 2'b00);
    chk("abort_outs", {get_cout(0), get_ovf(0), get_s(0)}, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) prev_s[i] = 8'h00;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_done = saw_done | get_done(0);
    end
    chk("abort_no_done", saw_done, 1'b0);
    run_op(0, 8'h10, 8'h20, 1'b0);
    chk("after_abort_sum", get_s(0), 8'h30);

    // Randomized operations across all digit sizes
    for (int i = 0; i < 10000; i++) begin
      sel = i % 4;
      run_op(sel, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
